adder_16bit_serial: RTL and testbench

Nibble-serial multi-word adder that sits directly above the 4-bit carry-lookahead slice in the datapath. It reuses one `adder_4bit` slice over several cycles to add two wide operands. It ripples the inter-nibble carry through a register, using the slice's group propagate/generate outputs. It produces the sum plus ALU flags behind a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/adder_4bit.sv | 36 +++
 rtl/adder_16bit_serial.sv | 137 +++++++++++++
 tb/tb_adder_16bit_serial.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg                                                          |
// | Shared datapath types: serial-adder FSM encodings, nibble width. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package cpu_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/adder_4bit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder_4bit                                                       |
// | 4-bit carry-lookahead slice with group propagate/generate out.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       pg,
  output logic       gg
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Flattened lookahead; no carry-out is exported, callers use pg/gg.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;
  assign pg  = &w_p;
  assign gg  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule : adder_4bit
`default_nettype wire

// File: rtl/adder_16bit_serial.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder_16bit_serial                                               |
// | Nibble-serial adder reusing one adder_4bit slice, with flags and |
// | valid/ready handshake. Optional subtract: define ADDER_SUB_EN.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module adder_16bit_serial
  import cpu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W*NIBBLES-1:0] in_a,
  input  logic [NIB_W*NIBBLES-1:0] in_b,
  input  logic                     in_cin,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NIBBLES-1:0] out_sum,
  output logic                     out_carry,
  output logic                     out_ovf,
  output logic                     out_zero
);

  localparam int c_width = NIB_W * NIBBLES;
  localparam int c_idx_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIBBLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic [c_width-1:0]   r_a;
  logic [c_width-1:0]   r_b;
  logic                 r_carry;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_width-1:0]   w_b_eff;
  logic                 w_cin0;
  logic [NIB_W-1:0]     w_nib_a;
  logic [NIB_W-1:0]     w_nib_b;
  logic [NIB_W-1:0]     w_slice_sum;
  logic                 w_pg;
  logic                 w_gg;

`ifdef ADDER_SUB_EN
  // Subtraction as a + ~b + 1; carry out of 1 then means no borrow.
  assign w_b_eff = in_sub ? ~in_b : in_b;
  assign w_cin0  = in_sub ? 1'b1 : in_cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = in_sub;
  assign w_b_eff      = in_b;
  assign w_cin0       = in_cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_idx == c_last_idx) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_nib_a = '0;
    w_nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_nib_a = r_a[i*NIB_W +: NIB_W];
        w_nib_b = r_b[i*NIB_W +: NIB_W];
      end
    end
  end

  adder_4bit u_slice (
    .a   (w_nib_a),
    .b   (w_nib_b),
    .cin (r_carry),
    .sum (w_slice_sum),
    .pg  (w_pg),
    .gg  (w_gg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      out_sum <= '0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= w_b_eff;
      r_carry <= w_cin0;
      r_idx   <= '0;
      out_sum <= '0;
    end else if (r_state == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (r_idx == c_idx_w'(i)) out_sum[i*NIB_W +: NIB_W] <= w_slice_sum;
      end
      r_carry <= w_gg | (w_pg & r_carry);
      r_idx   <= r_idx + c_idx_w'(1);
    end
  end

  // Flags only report in DONE so they read zero out of reset and mid-run.
  assign out_carry = out_valid & r_carry;
  assign out_ovf   = out_valid & (r_a[c_width-1] == r_b[c_width-1])
                   & (out_sum[c_width-1] != r_a[c_width-1]);
  assign out_zero  = out_valid & ~|out_sum;

endmodule : adder_16bit_serial
`default_nettype wire

// File: tb/tb_adder_16bit_serial.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_adder_16bit_serial                                            |
// | Directed self-checking bench for adder_16bit_serial.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_adder_16bit_serial;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;

  int n_compared;
  int n_mismatched;

  adder_16bit_serial #(.NIBBLES(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Accept one operation, then wait (bounded) for out_valid; returns
  // number of rising edges from accept edge until out_valid observed.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, output int lat);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic op_check(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic sub,
                          input logic [15:0] exp_sum, input logic exp_c,
                          input logic exp_v, input logic exp_z);
    int lat;
    start_op(a, b, cin, sub, lat);
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_sum"}, {16'd0, out_sum}, {16'd0, exp_sum});
    check({tag, "_carry"}, {31'd0, out_carry}, {31'd0, exp_c});
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, exp_v});
    check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp_z});
    finish_op(tag);
  endtask

  initial begin
    int lat;
    logic [15:0] held_sum;
    n_compared   = 0;
    n_mismatched = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check("rst_flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op_check("wrap", 16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    op_check("ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op_check("cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);

    // Backpressure: result must hold while new operands are offered.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    check("bp_latency", lat, 32'd4);
    held_sum = 16'h3333;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a     = 16'hA000 + 16'(i);
      in_b     = 16'h0F0F;
      @(posedge clk);
      #1;
      check("bp_sum", {16'd0, out_sum}, {16'd0, held_sum});
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    finish_op("bp");
    repeat (6) @(posedge clk);
    #1;
    check("bp_no_second", {30'd0, out_valid, in_ready}, 32'd1);

    // Reset after two nibbles have been processed.
    in_a     = 16'hFFFF;
    in_b     = 16'h0001;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {16'd0, out_sum}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    op_check("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);

`ifdef ADDER_SUB_EN
    op_check("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op_check("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`else
    op_check("sub_ign", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_adder_16bit_serial
`default_nettype wire
